// File: rtl/feynman_vector_driver.sv
// feynman_vector_driver
//   Exhaustive stimulus driver and checker for a double Feynman gate
//   (p=a, q=a^b, r=a^c). Each run sweeps {a,b,c} from 000 to 111 PASSES
//   times. Every vector is held SETTLE cycles and then checked for one cycle.
//   Mismatches are counted with saturation, and the first failing vector is
//   captured.
//
// Ports
//   clk             rising-edge clock
//   rst             synchronous active-high reset
//   start           run request, sampled only in IDLE
//   a, b, c         registered stimulus; forced to 0 outside APPLY/CHECK
//   p, q, r         gate response, combinational from a, b, c
//   busy            high while a run is in progress (APPLY/CHECK)
//   done            one-cycle pulse in the DONE state
//   pass            last completed run had zero mismatches
//   err_count       saturating mismatch count for the current/last run
//   first_err_vec   {a,b,c} of the first mismatching vector
//   first_err_valid first_err_vec holds a captured value
module feynman_vector_driver #(
  parameter int SETTLE = 1,
  parameter int PASSES = 1,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             c,
  input  logic             p,
  input  logic             q,
  input  logic             r,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [2:0]       first_err_vec,
  output logic             first_err_valid
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_APPLY = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef struct packed {
    logic p;
    logic q;
    logic r;
  } resp_t;

  logic [1:0]       state;
  logic [3:0]       settle_cnt;
  logic [7:0]       pass_cnt;
  logic [2:0]       vec;
  resp_t            exp_rsp, got_rsp;
  logic             mismatch;
  logic [ERR_W-1:0] err_inc;
  logic [ERR_W-1:0] err_final;
  logic             last_vec, last_pass, settle_end;

  // The vector register is the stimulus itself; the outputs read it directly.
  assign vec        = {a, b, c};
  assign exp_rsp    = '{p: a, q: a ^ b, r: a ^ c};
  assign got_rsp    = '{p: p, q: q, r: r};
  assign mismatch   = (exp_rsp != got_rsp);
  assign err_inc    = (&err_count) ? err_count : err_count + 1'b1;
  // Count as it will stand after this CHECK edge; pass is derived from it.
  assign err_final  = mismatch ? err_inc : err_count;
  assign last_vec   = (vec == 3'b111);
  assign last_pass  = (pass_cnt == 8'(PASSES - 1));
  assign settle_end = (settle_cnt == 4'(SETTLE - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      settle_cnt      <= '0;
      pass_cnt        <= '0;
      {a, b, c}       <= 3'b000;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_vec   <= 3'b000;
      first_err_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state           <= S_APPLY;
            settle_cnt      <= '0;
            pass_cnt        <= '0;
            {a, b, c}       <= 3'b000;
            busy            <= 1'b1;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_vec   <= 3'b000;
            first_err_valid <= 1'b0;
          end
        end
        S_APPLY: begin
          if (settle_end) begin
            state      <= S_CHECK;
            settle_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        S_CHECK: begin
          if (mismatch) begin
            err_count <= err_inc;
            if (!first_err_valid) begin
              first_err_vec   <= vec;
              first_err_valid <= 1'b1;
            end
          end
          if (last_vec && last_pass) begin
            state     <= S_DONE;
            {a, b, c} <= 3'b000;
            busy      <= 1'b0;
            done      <= 1'b1;
            pass      <= (err_final == '0);
          end else begin
            state     <= S_APPLY;
            {a, b, c} <= vec + 3'd1;   // 111 wraps to 000 for the next sweep
            if (last_vec) pass_cnt <= pass_cnt + 8'd1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_feynman_vector_driver.sv
// Bench for feynman_vector_driver. It instantiates three configurations:
//   0 = defaults, 1 = SETTLE=3, 2 = ERR_W=2 PASSES=2.
// Each configuration has its own gate model with a per-vector fault mask.
module tb_feynman_vector_driver;

  localparam int ST [3] = '{1, 3, 1};
  localparam int PS [3] = '{1, 1, 2};
  localparam int EW [3] = '{8, 8, 2};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]      st_v;
  logic [2:0]      busy_v, done_v, pass_v, fev_ok_v;
  logic [2:0][2:0] abc_v, fev_v;
  logic [2:0][7:0] err_v;
  logic [2:0]      fm [3][8];   // fault XOR mask {p,q,r} per vector

  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic aa, bb, cc, pp, qq, rr, bz, dn, ps, fvv;
    logic [2:0] fv;
    logic [EW[g]-1:0] ec;
    assign pp = aa ^ fm[g][{aa, bb, cc}][2];
    assign qq = (aa ^ bb) ^ fm[g][{aa, bb, cc}][1];
    assign rr = (aa ^ cc) ^ fm[g][{aa, bb, cc}][0];
    feynman_vector_driver #(.SETTLE(ST[g]), .PASSES(PS[g]), .ERR_W(EW[g])) u_dut (
      .clk(clk), .rst(rst), .start(st_v[g]),
      .a(aa), .b(bb), .c(cc), .p(pp), .q(qq), .r(rr),
      .busy(bz), .done(dn), .pass(ps), .err_count(ec),
      .first_err_vec(fv), .first_err_valid(fvv));
    assign busy_v[g]   = bz;
    assign done_v[g]   = dn;
    assign pass_v[g]   = ps;
    assign abc_v[g]    = {aa, bb, cc};
    assign err_v[g]    = 8'(ec);
    assign fev_v[g]    = fv;
    assign fev_ok_v[g] = fvv;
  end

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut=%0d t=%0t act=%0h exp=%0h", nm, d, $time, act, exp);
    end
  endtask

  // mode 0 ideal, 1 q stuck at 0, 2 r always inverted
  task automatic set_mode(input int d, input int mode);
    for (int v = 0; v < 8; v++) begin
      logic [2:0] vv;
      vv = 3'(v);
      case (mode)
        1:       fm[d][v] = {1'b0, vv[2] ^ vv[1], 1'b0};
        2:       fm[d][v] = 3'b001;
        default: fm[d][v] = 3'b000;
      endcase
    end
  endtask

  // Expected results from the fault masks alone.
  task automatic model(input int d, output logic [7:0] e, output logic [2:0] f,
                       output logic v, output logic ps);
    int nb, tot, sat;
    nb = 0; f = 3'b000; v = 1'b0;
    for (int i = 0; i < 8; i++)
      if (fm[d][i] != 3'b000) begin
        if (!v) f = 3'(i);
        v = 1'b1;
        nb++;
      end
    tot = nb * PS[d];
    sat = (1 << EW[d]) - 1;
    e   = 8'((tot > sat) ? sat : tot);
    ps  = (nb == 0);
  endtask

  // Start a run and trace every cycle against the expected timeline.
  task automatic run(input int d, input bit hold, input logic [7:0] ee,
                     input logic [2:0] ef, input logic ev, input logic ep);
    int n;
    logic [2:0] ex_abc;
    n = PS[d] * 8 * (ST[d] + 1);
    @(negedge clk); st_v[d] = 1'b1;
    @(negedge clk);
    if (!hold) st_v[d] = 1'b0;
    for (int k = 1; k <= n + 1; k++) begin
      ex_abc = (k <= n) ? 3'(((k - 1) / (ST[d] + 1)) % 8) : 3'b000;
      chk("busy", d, busy_v[d], k <= n);
      chk("done", d, done_v[d], k == n + 1);
      chk("abc", d, abc_v[d], ex_abc);
      if (k == n + 1) begin
        chk("pass_in_done", d, pass_v[d], ep);
        chk("err_in_done", d, err_v[d], ee);
      end
      @(negedge clk);
    end
    chk("idle_busy", d, busy_v[d], 0);
    chk("idle_done", d, done_v[d], 0);
    chk("err_count", d, err_v[d], ee);
    chk("first_err_valid", d, fev_ok_v[d], ev);
    if (ev) chk("first_err_vec", d, fev_v[d], ef);
    chk("pass", d, pass_v[d], ep);
    if (hold) begin
      @(negedge clk);
      chk("restart_busy", d, busy_v[d], 1);
      chk("restart_abc", d, abc_v[d], 0);
      st_v[d] = 1'b0;
      begin
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < n + 8 && !seen; k++) begin
          @(negedge clk);
          if (done_v[d]) seen = 1'b1;
        end
        chk("second_run_done", d, seen, 1);
      end
      @(negedge clk);
    end
  endtask

  typedef struct {
    int         d;
    int         mode;
    logic [7:0] ee;
    logic [2:0] ef;
    logic       ev;
    logic       ep;
  } tv_t;

  tv_t tbl [6];

  initial begin
    tbl[0] = '{d: 0, mode: 0, ee: 8'd0, ef: 3'b000, ev: 1'b0, ep: 1'b1};
    tbl[1] = '{d: 0, mode: 1, ee: 8'd4, ef: 3'b010, ev: 1'b1, ep: 1'b0};
    tbl[2] = '{d: 2, mode: 2, ee: 8'd3, ef: 3'b000, ev: 1'b1, ep: 1'b0};
    tbl[3] = '{d: 1, mode: 0, ee: 8'd0, ef: 3'b000, ev: 1'b0, ep: 1'b1};
    tbl[4] = '{d: 0, mode: 2, ee: 8'd8, ef: 3'b000, ev: 1'b1, ep: 1'b0};
    tbl[5] = '{d: 2, mode: 0, ee: 8'd0, ef: 3'b000, ev: 1'b0, ep: 1'b1};

    rst  = 1'b1;
    st_v = 3'b000;
    for (int d = 0; d < 3; d++) set_mode(d, 0);
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("rst_busy", d, busy_v[d], 0);
      chk("rst_done", d, done_v[d], 0);
      chk("rst_pass", d, pass_v[d], 0);
      chk("rst_err", d, err_v[d], 0);
      chk("rst_fev", d, fev_v[d], 0);
      chk("rst_fev_valid", d, fev_ok_v[d], 0);
      chk("rst_abc", d, abc_v[d], 0);
    end
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      set_mode(tbl[i].d, tbl[i].mode);
      run(tbl[i].d, 1'b0, tbl[i].ee, tbl[i].ef, tbl[i].ev, tbl[i].ep);
    end

    // Randomized fault masks checked against the model.
    for (int i = 0; i < 8; i++) begin
      int d;
      logic [7:0] e; logic [2:0] f; logic v, ps;
      d = (i % 3);
      for (int j = 0; j < 8; j++)
        fm[d][j] = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      model(d, e, f, v, ps);
      run(d, 1'b0, e, f, v, ps);
    end

    // start held high: back-to-back runs, no restart while busy.
    set_mode(0, 0);
    run(0, 1'b1, 8'd0, 3'b000, 1'b0, 1'b1);

    // Reset while vector 011 is in APPLY aborts the run with no done pulse.
    set_mode(0, 1);
    @(negedge clk); st_v[0] = 1'b1;
    @(negedge clk); st_v[0] = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_rst_abc", 0, abc_v[0], 3'b011);
    chk("pre_rst_err", 0, err_v[0], 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 0, busy_v[0], 0);
    chk("abort_abc", 0, abc_v[0], 0);
    chk("abort_err", 0, err_v[0], 0);
    chk("abort_fev_valid", 0, fev_ok_v[0], 0);
    chk("abort_done", 0, done_v[0], 0);
    st_v[0] = 1'b1;   // rst wins over start
    @(negedge clk);
    chk("rst_over_start", 0, busy_v[0], 0);
    rst = 1'b0; st_v[0] = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      repeat (20) begin
        @(negedge clk);
        if (done_v[0] || busy_v[0]) seen = 1'b1;
      end
      chk("no_done_after_abort", 0, seen, 0);
    end
    set_mode(0, 0);
    run(0, 1'b0, 8'd0, 3'b000, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
